alu_share_arbiter: RTL

Shares the single 32-bit combinational ALU between two requesters: port 0 (execute stage) and port 1 (address-generation / auxiliary sequencer). It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin between simultaneous requests. It drives the ALU operand and op inputs from registers, captures `aluout`, and returns the result to the granted requester over a second valid/ready handshake. Illegal op codes are flagged.

---
 rtl/alu_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Request in cycle T, ALU operands registered in T+1, registered response in T+2; response held until taken.
module alu_share_arbiter #(
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_aluop,
  input  logic [31:0]         req0_a,
  input  logic [31:0]         req0_b,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_aluop,
  input  logic [31:0]         req1_a,
  input  logic [31:0]         req1_b,

  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,

  output logic [OP_WIDTH-1:0] aluop,
  output logic [31:0]         alumux1_out,
  output logic [31:0]         alumux2_out,
  input  logic [31:0]         aluout,

  output logic                busy
);

  localparam logic [OP_WIDTH-1:0] FIRST_ILLEGAL_OP = OP_WIDTH'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   aluop_q, aluop_d;
  logic [31:0]           opa_q, opa_d;
  logic [31:0]           opb_q, opb_d;
  logic                  err_q, err_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;

  logic                  any_req;
  logic                  grant;
  logic [OP_WIDTH-1:0]   sel_op;
  logic                  owner_rsp_ready;

  // Contention goes to whichever port did not win last; a lone requester always wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    sel_op          = grant ? req1_aluop : req0_aluop;
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == S_IDLE) && req1_valid &&  grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    aluop_d      = aluop_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          aluop_d      = sel_op;
          opa_d        = grant ? req1_a : req0_a;
          opb_d        = grant ? req1_b : req0_b;
          owner_d      = grant;
          last_grant_d = grant;
          err_d        = (sel_op >= FIRST_ILLEGAL_OP);
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU has had a full cycle on the registered operands; sample it now.
        rsp_data_d   = aluout;
        rsp_err_d    = err_q;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d =  owner_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      aluop_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      err_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      aluop_q      <= aluop_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign aluop       = aluop_q;
  assign alumux1_out = opa_q;
  assign alumux2_out = opb_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign busy        = (state_q != S_IDLE);

endmodule
